// File: rtl/rv_core_pkg.sv
// Shared core definitions: default widths, writeback entry layout and
// the writeback buffer occupancy states.
package rv_core_pkg;

   localparam int ADDR_WIDTH = 5;
   localparam int DATA_WIDTH = 32;

   // One retiring instruction as seen by the writeback stage.
   typedef struct packed {
      logic                  reg_wr;
      logic [ADDR_WIDTH-1:0] rd;
      logic [DATA_WIDTH-1:0] result;
   } wb_entry_t;

   // Occupancy of the two-entry writeback buffer.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } wb_state_t;

endpackage

// File: rtl/wb_fifo2.sv
// Two-entry in-order buffer for writeback entries. Entry 0 is always the
// head (oldest); entry 1 is only meaningful in FULL. Both entries are
// visible so the parent can run bypass compares against them.
//
// Handshake: i_push must already be qualified by the parent (offer valid
// and buffer not FULL); i_pop must already be qualified (buffer not EMPTY
// and write port available). A slot that is vacated is cleared to zero.
module wb_fifo2
   import rv_core_pkg::*;
#(
   parameter int addr_width = ADDR_WIDTH,
   parameter int data_width = DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_push,
   input  logic                  i_pop,
   input  logic                  i_reg_wr,
   input  logic [addr_width-1:0] i_rd,
   input  logic [data_width-1:0] i_data,
   output logic [1:0]            o_state,
   output logic                  o_e0_wr,
   output logic [addr_width-1:0] o_e0_rd,
   output logic [data_width-1:0] o_e0_data,
   output logic                  o_e1_wr,
   output logic [addr_width-1:0] o_e1_rd,
   output logic [data_width-1:0] o_e1_data
);

   wb_state_t             r_state;
   logic                  r_e0_wr;
   logic [addr_width-1:0] r_e0_rd;
   logic [data_width-1:0] r_e0_data;
   logic                  r_e1_wr;
   logic [addr_width-1:0] r_e1_rd;
   logic [data_width-1:0] r_e1_data;

   // Occupancy FSM and entry storage; push-with-pop in ONE replaces the head.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= EMPTY;
         r_e0_wr   <= 1'b0;
         r_e0_rd   <= '0;
         r_e0_data <= '0;
         r_e1_wr   <= 1'b0;
         r_e1_rd   <= '0;
         r_e1_data <= '0;
      end else begin
         case (r_state)
            EMPTY: begin
               if (i_push) begin
                  r_e0_wr   <= i_reg_wr;
                  r_e0_rd   <= i_rd;
                  r_e0_data <= i_data;
                  r_state   <= ONE;
               end
            end
            ONE: begin
               if (i_push && i_pop) begin
                  r_e0_wr   <= i_reg_wr;
                  r_e0_rd   <= i_rd;
                  r_e0_data <= i_data;
               end else if (i_push) begin
                  r_e1_wr   <= i_reg_wr;
                  r_e1_rd   <= i_rd;
                  r_e1_data <= i_data;
                  r_state   <= FULL;
               end else if (i_pop) begin
                  r_e0_wr   <= 1'b0;
                  r_e0_rd   <= '0;
                  r_e0_data <= '0;
                  r_state   <= EMPTY;
               end
            end
            FULL: begin
               if (i_pop) begin
                  r_e0_wr   <= r_e1_wr;
                  r_e0_rd   <= r_e1_rd;
                  r_e0_data <= r_e1_data;
                  r_e1_wr   <= 1'b0;
                  r_e1_rd   <= '0;
                  r_e1_data <= '0;
                  r_state   <= ONE;
               end
            end
            default: r_state <= EMPTY;
         endcase
      end
   end

   assign o_state   = r_state;
   assign o_e0_wr   = r_e0_wr;
   assign o_e0_rd   = r_e0_rd;
   assign o_e0_data = r_e0_data;
   assign o_e1_wr   = r_e1_wr;
   assign o_e1_rd   = r_e1_rd;
   assign o_e1_data = r_e1_data;

endmodule

// File: rtl/writeback_phase.sv
// Writeback stage: buffers up to two execute results, drains them in
// order into the register-file write port, bypasses buffered results to
// decode, and counts drained entries.
//
// Handshake: a result transfers on a rising edge where ex_valid and
// ex_ready are both 1; ex_ready is 0 in FULL and while rst is high. The
// write port has no ready, only wr_stall: an entry drains on any edge
// where the buffer is non-empty and wr_stall is 0.
module writeback_phase
   import rv_core_pkg::*;
#(
   parameter int addr_width = ADDR_WIDTH,
   parameter int data_width = DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ex_valid,
   output logic                  ex_ready,
   input  logic                  ex_reg_wr,
   input  logic [addr_width-1:0] ex_rd,
   input  logic [data_width-1:0] ex_result,
   input  logic                  wr_stall,
   output logic                  wr_en,
   output logic [addr_width-1:0] wr_addr,
   output logic [data_width-1:0] wr_data,
   input  logic [addr_width-1:0] fwd_addr1,
   input  logic [addr_width-1:0] fwd_addr2,
   output logic                  fwd_hit1,
   output logic                  fwd_hit2,
   output logic [data_width-1:0] fwd_data1,
   output logic [data_width-1:0] fwd_data2,
   output logic [15:0]           retired
);

   logic [1:0]            w_state;
   logic                  w_v0;
   logic                  w_v1;
   logic                  w_push;
   logic                  w_pop;
   logic                  w_e0_wr;
   logic [addr_width-1:0] w_e0_rd;
   logic [data_width-1:0] w_e0_data;
   logic                  w_e1_wr;
   logic [addr_width-1:0] w_e1_rd;
   logic [data_width-1:0] w_e1_data;
   logic                  w_m0_1;
   logic                  w_m1_1;
   logic                  w_m0_2;
   logic                  w_m1_2;
   logic [15:0]           r_retired;

   assign w_v0     = (w_state != EMPTY);
   assign w_v1     = (w_state == FULL);
   assign ex_ready = ~rst & ~w_v1;
   assign w_push   = ex_valid & ex_ready;
   // Reset must never let a buffered entry reach the register file.
   assign w_pop    = ~rst & w_v0 & ~wr_stall;

   wb_fifo2 #(
      .addr_width (addr_width),
      .data_width (data_width)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .i_push    (w_push),
      .i_pop     (w_pop),
      .i_reg_wr  (ex_reg_wr),
      .i_rd      (ex_rd),
      .i_data    (ex_result),
      .o_state   (w_state),
      .o_e0_wr   (w_e0_wr),
      .o_e0_rd   (w_e0_rd),
      .o_e0_data (w_e0_data),
      .o_e1_wr   (w_e1_wr),
      .o_e1_rd   (w_e1_rd),
      .o_e1_data (w_e1_data)
   );

   // Writes to x0 still drain but never strobe the write port.
   assign wr_en   = w_pop & w_e0_wr & (w_e0_rd != '0);
   assign wr_addr = w_v0 ? w_e0_rd   : '0;
   assign wr_data = w_v0 ? w_e0_data : '0;

   // Bypass: entry 1 is younger than entry 0, so it wins when both match.
   assign w_m0_1 = w_v0 & w_e0_wr & (fwd_addr1 != '0) & (w_e0_rd == fwd_addr1);
   assign w_m1_1 = w_v1 & w_e1_wr & (fwd_addr1 != '0) & (w_e1_rd == fwd_addr1);
   assign w_m0_2 = w_v0 & w_e0_wr & (fwd_addr2 != '0) & (w_e0_rd == fwd_addr2);
   assign w_m1_2 = w_v1 & w_e1_wr & (fwd_addr2 != '0) & (w_e1_rd == fwd_addr2);

   assign fwd_hit1  = w_m0_1 | w_m1_1;
   assign fwd_hit2  = w_m0_2 | w_m1_2;
   assign fwd_data1 = w_m1_1 ? w_e1_data : (w_m0_1 ? w_e0_data : '0);
   assign fwd_data2 = w_m1_2 ? w_e1_data : (w_m0_2 ? w_e0_data : '0);

   // Drained-entry counter, free-running modulo 2^16.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_retired <= '0;
      end else if (w_pop) begin
         r_retired <= r_retired + 16'd1;
      end
   end

   assign retired = r_retired;

endmodule

// File: tb/tb_writeback_phase.sv
// Bench for writeback_phase: directed scenarios plus randomized traffic
// checked against a queue-based model of the buffer.
module tb_writeback_phase;
   import rv_core_pkg::*;

   logic        clk;
   logic        rst;
   logic        ex_valid;
   logic        ex_ready;
   logic        ex_reg_wr;
   logic [4:0]  ex_rd;
   logic [31:0] ex_result;
   logic        wr_stall;
   logic        wr_en;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;
   logic [4:0]  fwd_addr1;
   logic [4:0]  fwd_addr2;
   logic        fwd_hit1;
   logic        fwd_hit2;
   logic [31:0] fwd_data1;
   logic [31:0] fwd_data2;
   logic [15:0] retired;

   int total = 0;
   int bad   = 0;

   writeback_phase #(.addr_width(5), .data_width(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .ex_valid  (ex_valid),
      .ex_ready  (ex_ready),
      .ex_reg_wr (ex_reg_wr),
      .ex_rd     (ex_rd),
      .ex_result (ex_result),
      .wr_stall  (wr_stall),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .fwd_addr1 (fwd_addr1),
      .fwd_addr2 (fwd_addr2),
      .fwd_hit1  (fwd_hit1),
      .fwd_hit2  (fwd_hit2),
      .fwd_data1 (fwd_data1),
      .fwd_data2 (fwd_data2),
      .retired   (retired)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: in-order queue of buffered entries plus drain count.
   wb_entry_t   mq[$];
   logic [15:0] m_retired;

   function automatic logic m_ready();
      return !rst && (mq.size() < 2);
   endfunction

   function automatic logic m_pop();
      return !rst && (mq.size() > 0) && !wr_stall;
   endfunction

   function automatic logic m_wr_en();
      return m_pop() && mq[0].reg_wr && (mq[0].rd != 5'd0);
   endfunction

   function automatic logic [4:0] m_wr_addr();
      return (mq.size() > 0) ? mq[0].rd : 5'd0;
   endfunction

   function automatic logic [31:0] m_wr_data();
      return (mq.size() > 0) ? mq[0].result : 32'd0;
   endfunction

   function automatic logic m_hit(input logic [4:0] a);
      for (int i = mq.size() - 1; i >= 0; i--)
         if (a != 5'd0 && mq[i].reg_wr && mq[i].rd == a) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [31:0] m_fdata(input logic [4:0] a);
      for (int i = mq.size() - 1; i >= 0; i--)
         if (a != 5'd0 && mq[i].reg_wr && mq[i].rd == a) return mq[i].result;
      return 32'd0;
   endfunction

   // Advance one clock edge, updating the model from the inputs held
   // across it. Returns 1 ns after the edge.
   task automatic tick();
      logic      p;
      logic      q;
      wb_entry_t e;
      p = m_pop();
      q = ex_valid && m_ready();
      e.reg_wr = ex_reg_wr;
      e.rd     = ex_rd;
      e.result = ex_result;
      @(posedge clk);
      if (rst) begin
         mq.delete();
         m_retired = 16'd0;
      end else begin
         if (p) begin
            mq.delete(0);
            m_retired = m_retired + 16'd1;
         end
         if (q) mq.push_back(e);
      end
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; ex_valid = 1'b0; wr_stall = 1'b0;
      tick();
      rst = 1'b0;
   endtask

   task automatic push(input logic w, input logic [4:0] rd, input logic [31:0] d);
      ex_valid = 1'b1; ex_reg_wr = w; ex_rd = rd; ex_result = d;
      tick();
      ex_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      #1;
      total++; if (ex_ready !== 1'b0) begin bad++; $display("FAIL reset_ready_low: got %0b want 0", ex_ready); end
      rst = 1'b0; fwd_addr1 = 5'd5; fwd_addr2 = 5'd1;
      #1;
      total++; if (ex_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %0b want 1", ex_ready); end
      total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL reset_wr_en: got %0b want 0", wr_en); end
      total++; if (wr_addr !== 5'd0 || wr_data !== 32'd0) begin bad++; $display("FAIL reset_wr: got %0h/%0h want 0/0", wr_addr, wr_data); end
      total++; if (fwd_hit1 !== 1'b0 || fwd_data1 !== 32'd0 || fwd_hit2 !== 1'b0 || fwd_data2 !== 32'd0) begin bad++; $display("FAIL reset_fwd: got %0b %0h %0b %0h want all 0", fwd_hit1, fwd_data1, fwd_hit2, fwd_data2); end
      total++; if (retired !== 16'd0) begin bad++; $display("FAIL reset_retired: got %0h want 0", retired); end
   endtask

   task automatic test_single_write();
      do_reset();
      push(1'b1, 5'd5, 32'hDEADBEEF);
      #1;
      total++; if (wr_en !== 1'b1 || wr_addr !== 5'd5 || wr_data !== 32'hDEADBEEF) begin bad++; $display("FAIL single_write: got %0b/%0h/%0h want 1/5/deadbeef", wr_en, wr_addr, wr_data); end
      tick();
      #1;
      total++; if (retired !== 16'd1) begin bad++; $display("FAIL single_retired: got %0h want 1", retired); end
      total++; if (wr_en !== 1'b0 || wr_addr !== 5'd0) begin bad++; $display("FAIL single_drained: got %0b/%0h want 0/0", wr_en, wr_addr); end
   endtask

   task automatic test_x0();
      do_reset();
      push(1'b1, 5'd0, 32'h1234);
      #1;
      total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL x0_suppress: got %0b want 0", wr_en); end
      total++; if (wr_data !== 32'h1234) begin bad++; $display("FAIL x0_head_data: got %0h want 1234", wr_data); end
      tick();
      #1;
      total++; if (retired !== 16'd1 || wr_en !== 1'b0) begin bad++; $display("FAIL x0_pop: got retired=%0h wr_en=%0b want 1/0", retired, wr_en); end
   endtask

   task automatic test_stall_full();
      do_reset();
      wr_stall = 1'b1;
      push(1'b1, 5'd3, 32'hA);
      push(1'b1, 5'd4, 32'hB);
      #1;
      total++; if (ex_ready !== 1'b0 || wr_en !== 1'b0) begin bad++; $display("FAIL full_ready: got ready=%0b wr_en=%0b want 0/0", ex_ready, wr_en); end
      tick();
      #1;
      total++; if (wr_addr !== 5'd3 || wr_data !== 32'hA || wr_en !== 1'b0) begin bad++; $display("FAIL stall_stable: got %0b/%0h/%0h want 0/3/a", wr_en, wr_addr, wr_data); end
      wr_stall = 1'b0;
      #1;
      total++; if (wr_en !== 1'b1 || wr_addr !== 5'd3 || wr_data !== 32'hA) begin bad++; $display("FAIL drain_x3: got %0b/%0h/%0h want 1/3/a", wr_en, wr_addr, wr_data); end
      tick();
      #1;
      total++; if (wr_en !== 1'b1 || wr_addr !== 5'd4 || wr_data !== 32'hB || ex_ready !== 1'b1) begin bad++; $display("FAIL drain_x4: got %0b/%0h/%0h ready=%0b want 1/4/b ready=1", wr_en, wr_addr, wr_data, ex_ready); end
      tick();
      #1;
      total++; if (wr_en !== 1'b0 || retired !== 16'd2) begin bad++; $display("FAIL drain_done: got wr_en=%0b retired=%0h want 0/2", wr_en, retired); end
   endtask

   task automatic test_forwarding();
      do_reset();
      wr_stall = 1'b1;
      push(1'b1, 5'd7, 32'h11);
      push(1'b1, 5'd7, 32'h22);
      fwd_addr1 = 5'd7; fwd_addr2 = 5'd0;
      #1;
      total++; if (fwd_hit1 !== 1'b1 || fwd_data1 !== 32'h22) begin bad++; $display("FAIL fwd_youngest: got %0b/%0h want 1/22", fwd_hit1, fwd_data1); end
      total++; if (fwd_hit2 !== 1'b0 || fwd_data2 !== 32'd0) begin bad++; $display("FAIL fwd_x0: got %0b/%0h want 0/0", fwd_hit2, fwd_data2); end
      fwd_addr2 = 5'd9;
      #1;
      total++; if (fwd_hit2 !== 1'b0 || fwd_data2 !== 32'd0) begin bad++; $display("FAIL fwd_miss: got %0b/%0h want 0/0", fwd_hit2, fwd_data2); end
      wr_stall = 1'b0;
      tick();
      #1;
      total++; if (fwd_hit1 !== 1'b1 || fwd_data1 !== 32'h22) begin bad++; $display("FAIL fwd_after_pop: got %0b/%0h want 1/22", fwd_hit1, fwd_data1); end
      tick();
   endtask

   task automatic test_reset_mid();
      do_reset();
      wr_stall = 1'b1;
      push(1'b1, 5'd3, 32'h33);
      push(1'b1, 5'd4, 32'h44);
      rst = 1'b1; ex_valid = 1'b1; ex_reg_wr = 1'b1; ex_rd = 5'd6; ex_result = 32'h66;
      wr_stall = 1'b0;
      #1;
      total++; if (wr_en !== 1'b0 || ex_ready !== 1'b0) begin bad++; $display("FAIL rst_mid_during: got wr_en=%0b ready=%0b want 0/0", wr_en, ex_ready); end
      tick();
      rst = 1'b0; ex_valid = 1'b0; fwd_addr1 = 5'd6; fwd_addr2 = 5'd3;
      #1;
      total++; if (ex_ready !== 1'b1 || retired !== 16'd0) begin bad++; $display("FAIL rst_mid_after: got ready=%0b retired=%0h want 1/0", ex_ready, retired); end
      total++; if (wr_en !== 1'b0 || wr_addr !== 5'd0 || fwd_hit1 !== 1'b0 || fwd_hit2 !== 1'b0) begin bad++; $display("FAIL rst_mid_empty: got wr_en=%0b addr=%0h hit=%0b%0b want 0/0/00", wr_en, wr_addr, fwd_hit1, fwd_hit2); end
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 400; c++) begin
         rst       = ($urandom_range(0, 49) == 0);
         ex_valid  = 1'($urandom_range(0, 1));
         ex_reg_wr = ($urandom_range(0, 3) != 0);
         ex_rd     = 5'($urandom_range(0, 7));
         ex_result = $urandom;
         wr_stall  = ($urandom_range(0, 2) == 0);
         fwd_addr1 = 5'($urandom_range(0, 7));
         fwd_addr2 = 5'($urandom_range(0, 7));
         #1;
         total++; if (ex_ready !== m_ready()) begin bad++; $display("FAIL rnd_ready c=%0d: got %0b want %0b", c, ex_ready, m_ready()); end
         total++; if (wr_en !== m_wr_en()) begin bad++; $display("FAIL rnd_wr_en c=%0d: got %0b want %0b", c, wr_en, m_wr_en()); end
         total++; if (wr_addr !== m_wr_addr() || wr_data !== m_wr_data()) begin bad++; $display("FAIL rnd_wr c=%0d: got %0h/%0h want %0h/%0h", c, wr_addr, wr_data, m_wr_addr(), m_wr_data()); end
         total++; if (fwd_hit1 !== m_hit(fwd_addr1) || fwd_data1 !== m_fdata(fwd_addr1)) begin bad++; $display("FAIL rnd_fwd1 c=%0d: got %0b/%0h want %0b/%0h", c, fwd_hit1, fwd_data1, m_hit(fwd_addr1), m_fdata(fwd_addr1)); end
         total++; if (fwd_hit2 !== m_hit(fwd_addr2) || fwd_data2 !== m_fdata(fwd_addr2)) begin bad++; $display("FAIL rnd_fwd2 c=%0d: got %0b/%0h want %0b/%0h", c, fwd_hit2, fwd_data2, m_hit(fwd_addr2), m_fdata(fwd_addr2)); end
         total++; if (retired !== m_retired) begin bad++; $display("FAIL rnd_retired c=%0d: got %0h want %0h", c, retired, m_retired); end
         tick();
      end
      rst = 1'b0; ex_valid = 1'b0; wr_stall = 1'b0;
   endtask

   task automatic test_wrap();
      do_reset();
      ex_valid = 1'b1; ex_reg_wr = 1'b1; ex_rd = 5'd0; ex_result = 32'h0;
      // First edge only pushes; each later edge pushes and pops one entry.
      for (int i = 0; i < 65536; i++) tick();
      #1;
      total++; if (retired !== 16'hFFFF) begin bad++; $display("FAIL wrap_max: got %0h want ffff", retired); end
      tick();
      #1;
      total++; if (retired !== 16'h0000) begin bad++; $display("FAIL wrap_zero: got %0h want 0", retired); end
      ex_valid = 1'b0;
   endtask

   initial begin
      rst = 1'b1; ex_valid = 1'b0; ex_reg_wr = 1'b0; ex_rd = 5'd0; ex_result = 32'd0;
      wr_stall = 1'b0; fwd_addr1 = 5'd0; fwd_addr2 = 5'd0; m_retired = 16'd0;
      test_reset();
      test_single_write();
      test_x0();
      test_stall_full();
      test_forwarding();
      test_reset_mid();
      test_random();
      test_wrap();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
